// File: rtl/simple_proc_pkg.sv
// Shared opcodes, FSM states, instruction field positions and decode helpers
// for the simple processor core.
package simple_proc_pkg;

    typedef enum logic [3:0] {
        OP_ADD  = 4'h0,
        OP_SUB  = 4'h1,
        OP_AND  = 4'h2,
        OP_SYS  = 4'h3,
        OP_OR   = 4'h4,
        OP_XOR  = 4'h5,
        OP_SHL  = 4'h6,
        OP_SHR  = 4'h7,
        OP_LDI  = 4'h8,
        OP_ADDI = 4'h9,
        OP_LD   = 4'hA,
        OP_ST   = 4'hB,
        OP_BZ   = 4'hC,
        OP_BN   = 4'hD,
        OP_JMP  = 4'hE,
        OP_BC   = 4'hF
    } opcode_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_LATCH,
        S_EXEC,
        S_MEM,
        S_HALT
    } state_t;

    localparam logic [15:0] HALT_WORD = 16'h3C00;

    localparam int unsigned OP_LSB = 12;
    localparam int unsigned RD_LSB = 9;
    localparam int unsigned RS_LSB = 6;
    localparam int unsigned RT_LSB = 3;

    // Ops that produce a result through the ALU and therefore update flags.
    function automatic logic is_alu_op(input opcode_t op);
        case (op)
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR,
            OP_SHL, OP_SHR, OP_ADDI: return 1'b1;
            default:                 return 1'b0;
        endcase
    endfunction

    function automatic logic [15:0] sext6(input logic [5:0] v);
        return {{10{v[5]}}, v};
    endfunction

    function automatic logic [15:0] sext9(input logic [8:0] v);
        return {{7{v[8]}}, v};
    endfunction

endpackage

// File: rtl/simple_proc_core_if.sv
// Program-RAM / control bus of the simple processor core.
interface simple_proc_core_if #(
    parameter int PC_W = 10
);
    logic            start;
    logic [15:0]     data_in;
    logic [PC_W-1:0] pc;
    logic            ram_read_en;
    logic [15:0]     result;
    logic            zero;
    logic            negative;
    logic            overflow;
    logic            carry;
    logic            halted;

    modport master (
        input  start, data_in,
        output pc, ram_read_en, result, zero, negative, overflow, carry, halted
    );

    modport slave (
        output start, data_in,
        input  pc, ram_read_en, result, zero, negative, overflow, carry, halted
    );
endinterface

// File: rtl/reg_file_8x16.sv
// 8 x 16 register file: two combinational read ports, one synchronous write
// port, synchronous reset clears every entry.
module reg_file_8x16 (
    input  logic        clk,
    input  logic        reset,
    input  logic [2:0]  ra_addr,
    output logic [15:0] ra_data,
    input  logic [2:0]  rb_addr,
    output logic [15:0] rb_data,
    input  logic        we,
    input  logic [2:0]  w_addr,
    input  logic [15:0] w_data
);
    logic [15:0] regs [8];

    // Register storage: clear on reset, otherwise single write per cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned i = 0; i < 8; i++) begin
                regs[i] <= '0;
            end
        end else if (we) begin
            regs[w_addr] <= w_data;
        end
    end

    assign ra_data = regs[ra_addr];
    assign rb_data = regs[rb_addr];
endmodule

// File: rtl/simple_proc_core.sv
// Multi-cycle 16-bit core: FETCH / LATCH / EXEC (/ MEM for LD), 8x16
// register file, flag-producing ALU and a private synchronous data RAM.
module simple_proc_core
    import simple_proc_pkg::*;
#(
    parameter int PC_W    = 10,
    parameter int DRAM_AW = 8
) (
    input  logic               clk,
    input  logic               reset,
    simple_proc_core_if.master bus
);
    state_t          state;
    logic [15:0]     ir;
    logic [PC_W-1:0] pc_q;
    logic            rd_en_q;
    logic [15:0]     result_q;
    logic            z_q, n_q, v_q, c_q;
    logic            halted_q;

    logic [15:0]        dram [2**DRAM_AW];
    logic [15:0]        dram_q;
    logic [DRAM_AW-1:0] dram_addr;

    opcode_t     op;
    logic [2:0]  rd, rs, rt;
    logic [15:0] imm6_x, imm9_x;
    logic [15:0] a, b, addend;

    logic [16:0] wide;
    logic [15:0] alu_y;
    logic        alu_c, alu_v;

    logic [PC_W-1:0] pc_seq, br_tgt, pc_next;

    logic        rf_we;
    logic [15:0] rf_wdata;

    assign op     = opcode_t'(ir[OP_LSB +: 4]);
    assign rd     = ir[RD_LSB +: 3];
    assign rs     = ir[RS_LSB +: 3];
    assign rt     = ir[RT_LSB +: 3];
    assign imm6_x = sext6(ir[5:0]);
    assign imm9_x = sext9(ir[8:0]);

    // ST reads its data register through the second port in place of rt.
    reg_file_8x16 u_rf (
        .clk     (clk),
        .reset   (reset),
        .ra_addr (rs),
        .ra_data (a),
        .rb_addr ((op == OP_ST) ? rd : rt),
        .rb_data (b),
        .we      (rf_we),
        .w_addr  (rd),
        .w_data  (rf_wdata)
    );

    assign addend    = (op == OP_ADDI) ? imm6_x : b;
    assign dram_addr = a[DRAM_AW-1:0] + imm6_x[DRAM_AW-1:0];

    // ALU result plus carry/overflow for the current instruction.
    always_comb begin
        wide  = '0;
        alu_y = '0;
        alu_c = 1'b0;
        alu_v = 1'b0;
        case (op)
            OP_ADD, OP_ADDI: begin
                wide  = {1'b0, a} + {1'b0, addend};
                alu_y = wide[15:0];
                alu_c = wide[16];
                alu_v = (a[15] == addend[15]) && (alu_y[15] != a[15]);
            end
            OP_SUB: begin
                alu_y = a - b;
                alu_c = (a < b);
                alu_v = (a[15] != b[15]) && (alu_y[15] != a[15]);
            end
            OP_AND: alu_y = a & b;
            OP_OR:  alu_y = a | b;
            OP_XOR: alu_y = a ^ b;
            OP_SHL: begin
                alu_y = {a[14:0], 1'b0};
                alu_c = a[15];
            end
            OP_SHR: begin
                alu_y = {1'b0, a[15:1]};
                alu_c = a[0];
            end
            default: ;
        endcase
    end

    // Next PC: sequential, conditional branch relative to pc+1, or absolute jump.
    always_comb begin
        pc_seq  = pc_q + PC_W'(1);
        br_tgt  = pc_seq + imm6_x[PC_W-1:0];
        pc_next = pc_seq;
        case (op)
            OP_BZ:   if (z_q) pc_next = br_tgt;
            OP_BN:   if (n_q) pc_next = br_tgt;
            OP_BC:   if (c_q) pc_next = br_tgt;
            OP_JMP:  pc_next = ir[PC_W-1:0];
            default: ;
        endcase
    end

    // Register write port: ALU/LDI results in EXEC, load data in MEM.
    always_comb begin
        rf_we    = 1'b0;
        rf_wdata = alu_y;
        if (state == S_EXEC && (is_alu_op(op) || op == OP_LDI)) begin
            rf_we    = 1'b1;
            rf_wdata = (op == OP_LDI) ? imm9_x : alu_y;
        end else if (state == S_MEM) begin
            rf_we    = 1'b1;
            rf_wdata = dram_q;
        end
    end

    // Data RAM: store commits on the EXEC edge unless reset is sampled there.
    always_ff @(posedge clk) begin
        if (!reset && state == S_EXEC && op == OP_ST) begin
            dram[dram_addr] <= b;
        end
        dram_q <= dram[dram_addr];
    end

    // Control FSM with registered bus outputs, flags and result.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= S_IDLE;
            pc_q     <= '0;
            ir       <= '0;
            rd_en_q  <= 1'b0;
            result_q <= '0;
            z_q      <= 1'b0;
            n_q      <= 1'b0;
            v_q      <= 1'b0;
            c_q      <= 1'b0;
            halted_q <= 1'b0;
        end else begin
            if (rf_we) begin
                result_q <= rf_wdata;
            end
            case (state)
                S_IDLE: begin
                    if (bus.start) begin
                        state   <= S_FETCH;
                        rd_en_q <= 1'b1;
                    end
                end
                S_FETCH: begin
                    state   <= S_LATCH;
                    rd_en_q <= 1'b0;
                end
                S_LATCH: begin
                    ir    <= bus.data_in;
                    state <= S_EXEC;
                end
                S_EXEC: begin
                    if (is_alu_op(op)) begin
                        z_q <= (alu_y == '0);
                        n_q <= alu_y[15];
                        v_q <= alu_v;
                        c_q <= alu_c;
                    end
                    if (ir == HALT_WORD) begin
                        state    <= S_HALT;
                        halted_q <= 1'b1;
                    end else begin
                        pc_q <= pc_next;
                        if (op == OP_LD) begin
                            state <= S_MEM;
                        end else begin
                            state   <= S_FETCH;
                            rd_en_q <= 1'b1;
                        end
                    end
                end
                S_MEM: begin
                    state   <= S_FETCH;
                    rd_en_q <= 1'b1;
                end
                S_HALT: ;
                default: state <= S_IDLE;
            endcase
        end
    end

    assign bus.pc          = pc_q;
    assign bus.ram_read_en = rd_en_q;
    assign bus.result      = result_q;
    assign bus.zero        = z_q;
    assign bus.negative    = n_q;
    assign bus.overflow    = v_q;
    assign bus.carry       = c_q;
    assign bus.halted      = halted_q;
endmodule

// File: tb/tb_simple_proc_core.sv
// Bench for simple_proc_core: directed programs plus a random program,
// checked against an instruction-level model of the ISA.
module tb_simple_proc_core;

    logic clk = 1'b0;
    logic reset = 1'b1;

    simple_proc_core_if #(.PC_W(10)) bus ();

    simple_proc_core #(.PC_W(10), .DRAM_AW(8)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Program RAM, synchronous read.
    logic [15:0] prog [1024];
    always @(posedge clk) begin
        if (bus.ram_read_en) bus.data_in <= prog[bus.pc];
    end

    int total = 0;
    int bad   = 0;

    // Instruction-level reference state.
    int m_reg [8];
    int m_dram [256];
    int m_pc;
    int m_result;
    bit m_z, m_n, m_v, m_c, m_halted;

    function automatic logic [15:0] enc_r(int op, int rd, int rs, int rt);
        return {op[3:0], rd[2:0], rs[2:0], rt[2:0], 3'b000};
    endfunction
    function automatic logic [15:0] enc_i(int op, int rd, int rs, int imm);
        return {op[3:0], rd[2:0], rs[2:0], imm[5:0]};
    endfunction
    function automatic logic [15:0] enc_ldi(int rd, int imm);
        return {4'h8, rd[2:0], imm[8:0]};
    endfunction
    function automatic logic [15:0] enc_jmp(int addr);
        return {4'hE, 2'b00, addr[9:0]};
    endfunction
    function automatic logic [15:0] enc_br(int op, int imm);
        return {op[3:0], 6'b000000, imm[5:0]};
    endfunction

    function automatic int sgn(int x);
        return (x >= 32768) ? x - 65536 : x;
    endfunction
    function automatic bit ovf(int s);
        return (s > 32767) || (s < -32768);
    endfunction
    function automatic void set_flags(int r, bit c, bit v);
        m_z = (r == 0);
        m_n = (r >= 32768);
        m_c = c;
        m_v = v;
    endfunction

    // Execute one instruction in the model; returns its cycle count.
    task automatic model_step(output int cyc);
        logic [15:0] w;
        int op, rd, rs, rt, a, b, imm6, imm9, r, u, nxt;
        bit wr;
        w    = prog[m_pc];
        op   = int'(w[15:12]);
        rd   = int'(w[11:9]);
        rs   = int'(w[8:6]);
        rt   = int'(w[5:3]);
        imm6 = w[5] ? int'(w[5:0]) - 64 : int'(w[5:0]);
        imm9 = w[8] ? int'(w[8:0]) - 512 : int'(w[8:0]);
        a    = m_reg[rs];
        b    = m_reg[rt];
        r    = 0;
        wr   = 1'b0;
        cyc  = 3;
        nxt  = (m_pc + 1) % 1024;
        case (op)
            0: begin r = (a + b) % 65536; set_flags(r, (a + b) > 65535, ovf(sgn(a) + sgn(b))); wr = 1; end
            1: begin r = (a - b + 65536) % 65536; set_flags(r, a < b, ovf(sgn(a) - sgn(b))); wr = 1; end
            2: begin r = a & b; set_flags(r, 0, 0); wr = 1; end
            3: if (w == 16'h3C00) begin m_halted = 1; nxt = m_pc; end
            4: begin r = a | b; set_flags(r, 0, 0); wr = 1; end
            5: begin r = a ^ b; set_flags(r, 0, 0); wr = 1; end
            6: begin r = (a * 2) % 65536; set_flags(r, a >= 32768, 0); wr = 1; end
            7: begin r = a / 2; set_flags(r, (a % 2) == 1, 0); wr = 1; end
            8: begin r = (imm9 + 65536) % 65536; wr = 1; end
            9: begin
                u = a + (imm6 + 65536) % 65536;
                r = u % 65536;
                set_flags(r, u > 65535, ovf(sgn(a) + imm6));
                wr = 1;
            end
            10: begin r = m_dram[(a + imm6) & 255]; wr = 1; cyc = 4; end
            11: m_dram[(a + imm6) & 255] = m_reg[rd];
            12: if (m_z) nxt = (m_pc + 1 + imm6) & 1023;
            13: if (m_n) nxt = (m_pc + 1 + imm6) & 1023;
            14: nxt = int'(w[9:0]);
            15: if (m_c) nxt = (m_pc + 1 + imm6) & 1023;
            default: ;
        endcase
        if (wr) begin
            m_reg[rd] = r;
            m_result  = r;
        end
        m_pc = nxt;
    endtask

    task automatic clear_prog();
        for (int i = 0; i < 1024; i++) prog[i] = 16'h3C00;
    endtask

    // Reset, start the core, and leave it in FETCH of address 0.
    task automatic boot();
        reset     = 1'b1;
        bus.start = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset     = 1'b0;
        bus.start = 1'b1;
        for (int i = 0; i < 8; i++) m_reg[i] = 0;
        m_pc = 0; m_result = 0;
        m_z = 0; m_n = 0; m_v = 0; m_c = 0; m_halted = 0;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
    endtask

    // Run up to n instructions on model and DUT, stopping at HALT.
    task automatic advance(input int n);
        int cyc;
        for (int i = 0; i < n && !m_halted; i++) begin
            model_step(cyc);
            repeat (cyc) @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset();
        reset     = 1'b1;
        bus.start = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        total++; if (bus.pc !== 10'd0) begin bad++; $display("FAIL rst_pc got=%h exp=000", bus.pc); end
        total++; if (bus.ram_read_en !== 1'b0) begin bad++; $display("FAIL rst_rre got=%b exp=0", bus.ram_read_en); end
        total++; if ({bus.zero, bus.negative, bus.overflow, bus.carry} !== 4'b0000) begin
            bad++; $display("FAIL rst_flags got=%b exp=0000", {bus.zero, bus.negative, bus.overflow, bus.carry}); end
        total++; if (bus.halted !== 1'b0) begin bad++; $display("FAIL rst_halted got=%b exp=0", bus.halted); end
        total++; if (bus.result !== 16'h0000) begin bad++; $display("FAIL rst_result got=%h exp=0000", bus.result); end
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            total++;
            if (bus.ram_read_en !== 1'b0 || bus.pc !== 10'd0) begin
                bad++; $display("FAIL idle_nofetch cyc=%0d got rre=%b pc=%h exp rre=0 pc=000", i, bus.ram_read_en, bus.pc);
            end
        end
    endtask

    task automatic test_arith();
        clear_prog();
        prog[0] = enc_ldi(1, 5);
        prog[1] = enc_ldi(2, -3);
        prog[2] = enc_r(0, 3, 1, 2);
        prog[3] = enc_r(1, 4, 2, 1);
        prog[4] = 16'h3C00;
        boot();
        advance(3);
        total++; if (bus.result !== 16'h0002) begin bad++; $display("FAIL add_result got=%h exp=0002", bus.result); end
        total++; if ({bus.zero, bus.negative, bus.overflow, bus.carry} !== 4'b0001) begin
            bad++; $display("FAIL add_flags got=%b exp=0001", {bus.zero, bus.negative, bus.overflow, bus.carry}); end
        advance(1);
        total++; if (bus.result !== 16'hFFF8) begin bad++; $display("FAIL sub_result got=%h exp=fff8", bus.result); end
        total++; if ({bus.zero, bus.negative, bus.overflow, bus.carry} !== 4'b0100) begin
            bad++; $display("FAIL sub_flags got=%b exp=0100", {bus.zero, bus.negative, bus.overflow, bus.carry}); end
        advance(1);
        total++; if (bus.halted !== 1'b1) begin bad++; $display("FAIL halt_reached got=%b exp=1", bus.halted); end
        total++; if (bus.pc !== 10'd4) begin bad++; $display("FAIL halt_pc got=%h exp=004", bus.pc); end
        repeat (6) @(posedge clk);
        #1;
        total++; if (bus.pc !== 10'd4 || bus.ram_read_en !== 1'b0 || bus.halted !== 1'b1) begin
            bad++; $display("FAIL halt_frozen got pc=%h rre=%b halted=%b exp pc=004 rre=0 halted=1", bus.pc, bus.ram_read_en, bus.halted); end
    endtask

    task automatic test_flags();
        clear_prog();
        prog[0] = enc_ldi(1, 255);
        for (int i = 1; i <= 7; i++) prog[i] = enc_r(6, 1, 1, 0);
        for (int i = 8; i <= 11; i++) prog[i] = enc_i(9, 1, 1, 31);
        prog[12] = enc_i(9, 1, 1, 3);
        prog[13] = enc_i(9, 2, 1, 1);
        prog[14] = enc_ldi(3, -1);
        prog[15] = enc_i(9, 4, 3, 1);
        boot();
        advance(8);
        total++; if (bus.result !== 16'h7F80) begin bad++; $display("FAIL shl_chain got=%h exp=7f80", bus.result); end
        advance(5);
        total++; if (bus.result !== 16'h7FFF) begin bad++; $display("FAIL addi_chain got=%h exp=7fff", bus.result); end
        advance(1);
        total++; if (bus.result !== 16'h8000) begin bad++; $display("FAIL ovf_result got=%h exp=8000", bus.result); end
        total++; if ({bus.zero, bus.negative, bus.overflow, bus.carry} !== 4'b0110) begin
            bad++; $display("FAIL ovf_flags got=%b exp=0110", {bus.zero, bus.negative, bus.overflow, bus.carry}); end
        advance(1);
        total++; if (bus.result !== 16'hFFFF || {bus.zero, bus.negative, bus.overflow, bus.carry} !== 4'b0110) begin
            bad++; $display("FAIL ldi_keeps_flags got res=%h flags=%b exp res=ffff flags=0110", bus.result,
                            {bus.zero, bus.negative, bus.overflow, bus.carry}); end
        advance(1);
        total++; if (bus.result !== 16'h0000) begin bad++; $display("FAIL wrap_result got=%h exp=0000", bus.result); end
        total++; if ({bus.zero, bus.negative, bus.overflow, bus.carry} !== 4'b1001) begin
            bad++; $display("FAIL wrap_flags got=%b exp=1001", {bus.zero, bus.negative, bus.overflow, bus.carry}); end
    endtask

    task automatic test_memory();
        int cyc;
        clear_prog();
        prog[0] = enc_ldi(1, 10);
        prog[1] = enc_ldi(2, 123);
        prog[2] = enc_i(11, 2, 1, 2);
        prog[3] = enc_ldi(2, 5);
        prog[4] = enc_i(10, 3, 1, 2);
        boot();
        advance(4);
        total++; if (bus.result !== 16'd5 || bus.pc !== 10'd4) begin
            bad++; $display("FAIL mem_pre got res=%h pc=%h exp res=0005 pc=004", bus.result, bus.pc); end
        model_step(cyc);
        repeat (3) @(posedge clk);
        #1;
        total++; if (bus.ram_read_en !== 1'b0 || bus.result !== 16'd5) begin
            bad++; $display("FAIL ld_mem_cycle got rre=%b res=%h exp rre=0 res=0005", bus.ram_read_en, bus.result); end
        @(posedge clk);
        #1;
        total++; if (bus.result !== 16'd123 || bus.ram_read_en !== 1'b1 || bus.pc !== 10'd5) begin
            bad++; $display("FAIL ld_done got res=%h rre=%b pc=%h exp res=007b rre=1 pc=005", bus.result, bus.ram_read_en, bus.pc); end
        total++; if (dut.dram[12] !== 16'd123) begin bad++; $display("FAIL st_dram12 got=%h exp=007b", dut.dram[12]); end
    endtask

    task automatic test_branch();
        clear_prog();
        prog[0] = enc_ldi(1, 3);
        prog[1] = enc_i(9, 1, 1, -1);
        prog[2] = enc_br(12, 1);
        prog[3] = enc_jmp(1);
        prog[4] = 16'h3C00;
        boot();
        advance(3);
        total++; if (bus.pc !== 10'd3 || bus.zero !== 1'b0) begin
            bad++; $display("FAIL bz_not_taken got pc=%h z=%b exp pc=003 z=0", bus.pc, bus.zero); end
        advance(50);
        total++; if (bus.halted !== 1'b1 || bus.pc !== 10'd4) begin
            bad++; $display("FAIL loop_exit got halted=%b pc=%h exp halted=1 pc=004", bus.halted, bus.pc); end
        total++; if (bus.result !== 16'h0000 || bus.zero !== 1'b1) begin
            bad++; $display("FAIL loop_r1 got res=%h z=%b exp res=0000 z=1", bus.result, bus.zero); end
    endtask

    task automatic test_pc_wrap();
        clear_prog();
        prog[0]    = enc_jmp(1023);
        prog[1023] = 16'h3001;
        boot();
        advance(1);
        total++; if (bus.pc !== 10'd1023) begin bad++; $display("FAIL jmp_1023 got=%h exp=3ff", bus.pc); end
        advance(1);
        total++; if (bus.pc !== 10'd0 || bus.ram_read_en !== 1'b1) begin
            bad++; $display("FAIL pc_wrap got pc=%h rre=%b exp pc=000 rre=1", bus.pc, bus.ram_read_en); end
    endtask

    task automatic test_reset_abort();
        clear_prog();
        prog[0] = enc_ldi(1, 10);
        prog[1] = enc_ldi(2, 77);
        prog[2] = enc_i(11, 2, 1, 2);
        boot();
        advance(2);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        total++; if (dut.dram[12] !== 16'd123) begin bad++; $display("FAIL abort_st_dram got=%h exp=007b", dut.dram[12]); end
        total++; if (bus.pc !== 10'd0 || bus.ram_read_en !== 1'b0 || bus.halted !== 1'b0) begin
            bad++; $display("FAIL abort_state got pc=%h rre=%b halted=%b exp pc=000 rre=0 halted=0", bus.pc, bus.ram_read_en, bus.halted); end
        total++; if (bus.result !== 16'h0000) begin bad++; $display("FAIL abort_result got=%h exp=0000", bus.result); end
        repeat (5) @(posedge clk);
        #1;
        total++; if (bus.pc !== 10'd0 || bus.ram_read_en !== 1'b0) begin
            bad++; $display("FAIL abort_idle got pc=%h rre=%b exp pc=000 rre=0", bus.pc, bus.ram_read_en); end
    endtask

    task automatic test_random();
        int cyc;
        int idx;
        logic [15:0] w;
        for (int i = 0; i < 1024; i++) begin
            w = 16'($urandom);
            if (w == 16'h3C00) w = 16'h3C01;
            prog[i] = w;
        end
        // Prologue fills all 256 data words so random loads read known values.
        prog[0] = enc_ldi(1, -256);
        prog[1] = enc_i(11, 1, 1, 0);
        prog[2] = enc_i(9, 1, 1, 1);
        prog[3] = enc_br(12, 1);
        prog[4] = enc_jmp(1);
        boot();
        for (int s = 0; s < 1324; s++) begin
            model_step(cyc);
            repeat (cyc) @(posedge clk);
            #1;
            total++; if (bus.pc !== m_pc[9:0]) begin
                bad++; $display("FAIL rnd_pc step=%0d got=%h exp=%h", s, bus.pc, m_pc[9:0]); end
            total++; if (bus.result !== m_result[15:0]) begin
                bad++; $display("FAIL rnd_result step=%0d got=%h exp=%h", s, bus.result, m_result[15:0]); end
            total++; if ({bus.zero, bus.negative, bus.overflow, bus.carry} !== {m_z, m_n, m_v, m_c}) begin
                bad++; $display("FAIL rnd_flags step=%0d got=%b exp=%b", s,
                                {bus.zero, bus.negative, bus.overflow, bus.carry}, {m_z, m_n, m_v, m_c}); end
            total++; if (bus.ram_read_en !== 1'b1 || bus.halted !== 1'b0) begin
                bad++; $display("FAIL rnd_fetch step=%0d got rre=%b halted=%b exp rre=1 halted=0", s, bus.ram_read_en, bus.halted); end
        end
        for (int k = 0; k < 8; k++) begin
            idx = int'($urandom_range(255, 0));
            total++; if (dut.dram[idx] !== m_dram[idx][15:0]) begin
                bad++; $display("FAIL rnd_dram addr=%0d got=%h exp=%h", idx, dut.dram[idx], m_dram[idx][15:0]); end
        end
    endtask

    initial begin
        bus.start = 1'b0;
        for (int i = 0; i < 256; i++) m_dram[i] = 0;
        test_reset();
        test_arith();
        test_flags();
        test_memory();
        test_branch();
        test_pc_wrap();
        test_reset_abort();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog simulation did not complete in time");
        $fatal(1);
    end

endmodule
